// File: rtl/traffic_pkg.sv
// Shared lamp codes, approach directions and phase encodings for the intersection controller.
package traffic_pkg;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_E = 2'd1,
    DIR_S = 2'd2,
    DIR_W = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    PH_ALL_RED = 2'd0,
    PH_GREEN   = 2'd1,
    PH_YELLOW  = 2'd2
  } phase_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requesting approach after last_dir, wrapping, last_dir itself last.
module rr_pick
  import traffic_pkg::*;
(
  input  logic [3:0] req,
  input  dir_e       last_dir,
  output logic       pick_valid,
  output dir_e       pick_dir
);

  logic [1:0] idx;

  // Scan farthest-first so the nearest requester after last_dir is the final assignment.
  always_comb begin
    pick_valid = 1'b0;
    pick_dir   = last_dir;
    idx        = 2'd0;
    for (int i = 4; i >= 1; i--) begin
      idx = 2'(int'(last_dir) + i);
      if (req[idx]) begin
        pick_valid = 1'b1;
        pick_dir   = dir_e'(idx);
      end
    end
  end

endmodule

// File: rtl/traffic_phase_arbiter.sv
// Four-approach phase scheduler: round-robin grants, min/max green, yellow and all-red clearance, emergency preempt.
module traffic_phase_arbiter
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN   = 8,
  parameter int MAX_GREEN   = 32,
  parameter int YELLOW_CYC  = 4,
  parameter int ALL_RED_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       emg_valid,
  input  logic [1:0] emg_dir,
  output logic [2:0] north,
  output logic [2:0] east,
  output logic [2:0] south,
  output logic [2:0] west,
  output logic [1:0] grant_dir,
  output logic       grant_valid,
  output logic       phase_start
);

  localparam int CNT_TOP = (MAX_GREEN > YELLOW_CYC)
                           ? ((MAX_GREEN > ALL_RED_CYC) ? MAX_GREEN : ALL_RED_CYC)
                           : ((YELLOW_CYC > ALL_RED_CYC) ? YELLOW_CYC : ALL_RED_CYC);
  localparam int CW = $clog2(CNT_TOP + 1);

  localparam logic [CW-1:0] MIN_LAST = CW'(MIN_GREEN - 1);
  localparam logic [CW-1:0] MAX_LAST = CW'(MAX_GREEN - 1);
  localparam logic [CW-1:0] MAX_SAT  = CW'(MAX_GREEN);
  localparam logic [CW-1:0] Y_LAST   = CW'(YELLOW_CYC - 1);
  localparam logic [CW-1:0] AR_LAST  = CW'(ALL_RED_CYC - 1);

  phase_e        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  dir_e          last_dir, last_nx;

  logic pick_valid;
  dir_e pick_dir;
  logic own_req;
  logic other_req;
  logic gap_out;
  logic max_out;
  logic preempt;

  rr_pick u_rr_pick (
    .req        (req),
    .last_dir   (last_dir),
    .pick_valid (pick_valid),
    .pick_dir   (pick_dir)
  );

  // cnt counts completed cycles of the current phase, so cnt==0 marks its first cycle.
  always_comb begin
    own_req   = req[last_dir];
    other_req = |(req & ~(4'b0001 << last_dir));
    gap_out   = other_req && (cnt >= MIN_LAST) && !own_req;
    max_out   = other_req && (cnt >= MAX_LAST);
    preempt   = emg_valid && (emg_dir != last_dir);
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    last_nx  = last_dir;
    case (state)
      PH_ALL_RED: begin
        if (cnt >= AR_LAST) begin
          if (emg_valid) begin
            state_nx = PH_GREEN;
            last_nx  = dir_e'(emg_dir);
            cnt_nx   = '0;
          end else if (pick_valid) begin
            state_nx = PH_GREEN;
            last_nx  = pick_dir;
            cnt_nx   = '0;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      PH_GREEN: begin
        cnt_nx = (cnt == MAX_SAT) ? cnt : cnt + 1'b1;
        if (emg_valid) begin
          if (preempt) begin
            state_nx = PH_YELLOW;
            cnt_nx   = '0;
          end
        end else if (gap_out || max_out) begin
          state_nx = PH_YELLOW;
          cnt_nx   = '0;
        end
      end
      PH_YELLOW: begin
        if (cnt >= Y_LAST) begin
          state_nx = PH_ALL_RED;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = PH_ALL_RED;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= PH_ALL_RED;
      cnt      <= '0;
      last_dir <= DIR_W;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      last_dir <= last_nx;
    end
  end

  logic [2:0] active_lamp;

  always_comb begin
    grant_valid = (state == PH_GREEN) || (state == PH_YELLOW);
    grant_dir   = grant_valid ? last_dir : 2'd0;
    phase_start = (state == PH_GREEN) && (cnt == '0);
    active_lamp = (state == PH_GREEN) ? LAMP_GREEN : LAMP_YELLOW;
    north = (grant_valid && last_dir == DIR_N) ? active_lamp : LAMP_RED;
    east  = (grant_valid && last_dir == DIR_E) ? active_lamp : LAMP_RED;
    south = (grant_valid && last_dir == DIR_S) ? active_lamp : LAMP_RED;
    west  = (grant_valid && last_dir == DIR_W) ? active_lamp : LAMP_RED;
  end

endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// Directed bench for traffic_phase_arbiter with default timing parameters and a per-cycle lamp invariant monitor.
module tb_traffic_phase_arbiter;
  import traffic_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       emg_valid = 1'b0;
  logic [1:0] emg_dir = 2'd0;
  logic [2:0] north, east, south, west;
  logic [1:0] grant_dir;
  logic       grant_valid;
  logic       phase_start;

  int   checks = 0;
  int   errors = 0;
  logic inv_en = 1'b0;

  traffic_phase_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .emg_valid   (emg_valid),
    .emg_dir     (emg_dir),
    .north       (north),
    .east        (east),
    .south       (south),
    .west        (west),
    .grant_dir   (grant_dir),
    .grant_valid (grant_valid),
    .phase_start (phase_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] lamp_of(input logic [1:0] d);
    case (d)
      2'd0:    return north;
      2'd1:    return east;
      2'd2:    return south;
      default: return west;
    endcase
  endfunction

  function automatic logic inv_ok();
    int nonred;
    logic ok;
    ok = $onehot(north) && $onehot(east) && $onehot(south) && $onehot(west);
    nonred = int'(north != LAMP_RED) + int'(east != LAMP_RED)
           + int'(south != LAMP_RED) + int'(west != LAMP_RED);
    ok = ok && (nonred <= 1) && (nonred == int'(grant_valid));
    if (nonred == 1) ok = ok && (lamp_of(grant_dir) != LAMP_RED);
    return ok;
  endfunction

  always @(negedge clk) begin
    if (inv_en) check("invariant", 32'(inv_ok()), 32'd1);
  end

  task automatic wait_start();
    int n;
    n = 0;
    while (!phase_start && n < 300) begin
      tick();
      n++;
    end
    check("start_seen", 32'(phase_start), 32'd1);
  endtask

  task automatic measure(input logic [1:0] d, input int g0, output int g, output int y, output int r);
    g = g0;
    while (lamp_of(d) == LAMP_GREEN && g < 300) begin g++; tick(); end
    y = 0;
    while (lamp_of(d) == LAMP_YELLOW && y < 300) begin y++; tick(); end
    r = 0;
    while (!grant_valid && r < 300) begin r++; tick(); end
  endtask

  task automatic do_reset(input logic [3:0] r_req);
    rst = 1'b1;
    req = r_req;
    emg_valid = 1'b0;
    emg_dir = 2'd0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int g, y, r;
    logic seen_nonred, seen_gv, seen_ps, seen_bad;
    logic [1:0] order [0:4];
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // Idle intersection stays all red
    rst = 1'b1;
    tick();
    tick();
    inv_en = 1'b1;
    check("rst_north", 32'(north), 32'(LAMP_RED));
    check("rst_west", 32'(west), 32'(LAMP_RED));
    check("rst_gv", 32'(grant_valid), 32'd0);
    check("rst_ps", 32'(phase_start), 32'd0);
    check("rst_gdir", 32'(grant_dir), 32'd0);
    rst = 1'b0;
    seen_nonred = 1'b0; seen_gv = 1'b0; seen_ps = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      seen_nonred |= (north != LAMP_RED) || (east != LAMP_RED) || (south != LAMP_RED) || (west != LAMP_RED);
      seen_gv |= grant_valid;
      seen_ps |= phase_start;
    end
    check("idle_lamps", 32'(seen_nonred), 32'd0);
    check("idle_gv", 32'(seen_gv), 32'd0);
    check("idle_ps", 32'(seen_ps), 32'd0);

    // Lone north request: green one edge after release, rests indefinitely
    do_reset(4'b0001);
    tick();
    check("n_allred_k", 32'(north), 32'(LAMP_RED));
    tick();
    check("n_green_k1", 32'(north), 32'(LAMP_GREEN));
    check("n_ps_first", 32'(phase_start), 32'd1);
    check("n_gdir", 32'(grant_dir), 32'd0);
    seen_bad = 1'b0; seen_ps = 1'b0;
    for (int i = 0; i < 120; i++) begin
      tick();
      seen_bad |= (north != LAMP_GREEN);
      seen_ps |= phase_start;
    end
    check("n_rest_green", 32'(seen_bad), 32'd0);
    check("n_single_ps", 32'(seen_ps), 32'd0);

    // All approaches waiting: max-out rotation N,E,S,W,N
    do_reset(4'b1111);
    for (int i = 0; i < 4; i++) begin
      wait_start();
      check("rr_dir", 32'(grant_dir), 32'(order[i]));
      measure(order[i], 0, g, y, r);
      check("rr_green", 32'(g), 32'd32);
      check("rr_yellow", 32'(y), 32'd4);
      check("rr_allred", 32'(r), 32'd2);
    end
    wait_start();
    check("rr_wrap_dir", 32'(grant_dir), 32'(order[4]));

    // Gap-out: north releases at green cycle 3, east waiting
    do_reset(4'b0001);
    wait_start();
    tick();
    tick();
    req = 4'b0010;
    measure(2'd0, 2, g, y, r);
    check("gap_green", 32'(g), 32'd8);
    check("gap_yellow", 32'(y), 32'd4);
    check("gap_allred", 32'(r), 32'd2);
    check("gap_next_dir", 32'(grant_dir), 32'd1);
    check("gap_east_green", 32'(east), 32'(LAMP_GREEN));

    // Preempt to south during east green cycle 2, west skipped
    tick();
    emg_valid = 1'b1;
    emg_dir = 2'd2;
    req = 4'b1000;
    measure(2'd1, 1, g, y, r);
    check("emg_e_green", 32'(g), 32'd2);
    check("emg_e_yellow", 32'(y), 32'd4);
    check("emg_allred", 32'(r), 32'd2);
    check("emg_dir_s", 32'(grant_dir), 32'd2);
    check("emg_s_green", 32'(south), 32'(LAMP_GREEN));
    seen_bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      seen_bad |= (south != LAMP_GREEN);
    end
    check("emg_s_hold", 32'(seen_bad), 32'd0);

    // Reset during east yellow: immediate all red, then north first
    do_reset(4'b0010);
    wait_start();
    check("ry_e_dir", 32'(grant_dir), 32'd1);
    req = 4'b0001;
    g = 0;
    while (east != LAMP_YELLOW && g < 100) begin tick(); g++; end
    check("ry_e_yellow", 32'(east), 32'(LAMP_YELLOW));
    tick();
    rst = 1'b1;
    tick();
    check("ry_east_red", 32'(east), 32'(LAMP_RED));
    check("ry_gv", 32'(grant_valid), 32'd0);
    rst = 1'b0;
    req = 4'b1111;
    wait_start();
    check("ry_n_first", 32'(grant_dir), 32'd0);
    check("ry_n_green", 32'(north), 32'(LAMP_GREEN));

    inv_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_phase_arbiter.md
# traffic_phase_arbiter

Sensor-actuated phase scheduler for the 4-way intersection. It shares the single green phase among four approaches (N, E, S, W) from vehicle-presence requests, using round-robin fairness, min/max green timers, yellow and all-red clearance, and an emergency-preempt override. It drives the four 3-bit one-hot lamp buses that feed the intersection signal heads.

## Interface
- `MIN_GREEN`, default 8: minimum green cycles before gap-out; must be ≥ 1.
- `MAX_GREEN`, default 32: green cycles before max-out when others wait; must be ≥ `MIN_GREEN`.
- `YELLOW_CYC`, default 4: yellow duration in cycles; must be ≥ 1.
- `ALL_RED_CYC`, default 2: all-red clearance in cycles; must be ≥ 1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in 4: vehicle presence; bit0=N, bit1=E, bit2=S, bit3=W; level-sensitive.
- `emg_valid` in 1: emergency preempt request, level.
- `emg_dir` in 2: preempt direction (0=N … 3=W); valid only with `emg_valid`.
- `north`, `east`, `south`, `west` out 3 each: lamp codes RED=3'b100, YELLOW=3'b010, GREEN=3'b001.
- `grant_dir` out 2: direction currently served (green or yellow); meaningful only while `grant_valid`.
- `grant_valid` out 1: high in GREEN and YELLOW.
- `phase_start` out 1: one-cycle pulse on the first GREEN cycle of each grant.

## Operation
- FSM states: ALL_RED, GREEN, YELLOW. Outputs are a pure decode of the registered state, grant and pointer (Moore).
- Reset values: state ALL_RED, phase counter 0, round-robin pointer `last_dir` = W (N has first priority). All lamps RED, `grant_valid`=0, `phase_start`=0, `grant_dir`=0.
- **ALL_RED**:
  - After `ALL_RED_CYC` cycles, pick the next direction.
  - If `emg_valid`, pick `emg_dir`. Otherwise pick the first set `req` bit scanning `last_dir`+1, +2, +3, +4 (mod 4).
  - If nothing is picked, rest in ALL_RED and re-evaluate every cycle.
  - On a pick: go to GREEN, set `last_dir` to the picked direction, clear the counter.
- **GREEN**: the counter holds elapsed green cycles including the current one, and saturates at `MAX_GREEN`.
  - `other` = any `req` bit except the granted one.
  - Gap-out: `other` && counter ≥ `MIN_GREEN` && own `req`=0.
  - Max-out: `other` && counter ≥ `MAX_GREEN`.
  - Either gap-out or max-out moves the FSM to YELLOW. With no `other`, green rests indefinitely.
  - Preempt: `emg_valid` with `emg_dir` ≠ granted direction forces YELLOW on the next cycle, ignoring `MIN_GREEN`.
  - `emg_valid` with `emg_dir` = granted direction holds green, ignoring `req`. Normal rules resume when `emg_valid` drops; the counter keeps counting.
- **YELLOW**: lasts exactly `YELLOW_CYC` cycles, then ALL_RED. Preempt never shortens yellow or all-red.
- Invariants:
  - Every lamp bus is always exactly one-hot.
  - At most one bus is non-RED.
  - The non-RED bus is `grant_dir`.

## Timing
- A state change on edge k is visible on the lamp buses and status outputs immediately after edge k.
- Reset release: with `rst` low first sampled at edge k and `req`[0] high, `north`=GREEN from edge k+`ALL_RED_CYC` − 1. This ALL_RED stretch is `ALL_RED_CYC` cycles long, counting the cycle after edge k.
- Phase lengths:
  - GREEN ≥ `MIN_GREEN` cycles (preempt excepted).
  - GREEN is exactly `MAX_GREEN` cycles under max-out.
  - YELLOW is exactly `YELLOW_CYC` cycles.
  - ALL_RED is exactly `ALL_RED_CYC` cycles before any new grant.
- Simultaneous gap-out and preempt: preempt wins; both lead to YELLOW.
- `emg_dir` changing during yellow or all-red: the value sampled on the ALL_RED pick cycle wins.
- `rst` asserted in any state: the next cycle is ALL_RED with all reset values. There is no yellow on reset.
- Counter width is `$clog2(MAX_GREEN+1)` bits. There is no wrap, because the counter saturates.

## Structure
- Package `traffic_pkg` holds:
  - The RED/YELLOW/GREEN lamp constants.
  - Enum `dir_e` {DIR_N, DIR_E, DIR_S, DIR_W}.
  - Enum `phase_e` {PH_ALL_RED, PH_GREEN, PH_YELLOW}.
- Sub-module `rr_pick`: combinational round-robin picker. Inputs are `req[3:0]` and `last_dir`; outputs are `pick_valid` and `pick_dir`.
- The top level holds the FSM, the phase counter, the pointer and the lamp decode.

## Test plan
- Reset, then `req`=0 for 100 cycles -> all lamps 3'b100 throughout; `grant_valid`=0; `phase_start` never pulses.
- `req`=4'b0001 from reset release -> after 2 all-red cycles, `north`=3'b001 and stays green 100+ cycles; one `phase_start` pulse.
- `req`=4'b1111 constant -> grant order N, E, S, W, N. Each phase is exactly 32 green + 4 yellow + 2 all-red cycles. A one-hot/single-non-red checker runs every cycle.
- N green, `req`=4'b0010 from N green cycle 3 (N `req` low) -> N green through cycle 8, then 4 yellow, 2 all-red, then `east`=GREEN.
- E green at cycle 2, `emg_valid`=1 with `emg_dir`=2, `req`=4'b1000 -> E yellow next cycle, 4 yellow, 2 all-red, then S green (W skipped). S holds green while `emg_valid`=1.
- `rst` pulsed during yellow of E -> all RED next cycle. With `req`=4'b1111 afterwards, N is granted first.
